// File: rtl/fmul_norm_round.sv
// Normalize-and-round stage of the binary32 multiplier: two-deep valid/ready
// pipeline turning a 48-bit mantissa product into a packed RNE-rounded result.
`timescale 1ns/1ps
module fmul_norm_round (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [47:0] prod,
    input  logic        sign,
    input  logic [7:0]  exp_a,
    input  logic [7:0]  exp_b,
    input  logic [1:0]  cls,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        inexact
);

    logic               s1_valid_r;
    logic [22:0]        s1_mant_r;
    logic               s1_guard_r;
    logic               s1_sticky_r;
    logic signed [9:0]  s1_exp_r;
    logic               s1_sign_r;
    logic [1:0]         s1_cls_r;

    logic               s1_en_s;
    logic               s2_en_s;
    logic signed [9:0]  n1_exp_s;
    logic [22:0]        n1_mant_s;
    logic               n1_guard_s;
    logic               n1_sticky_s;

    logic               round_up_s;
    logic [23:0]        m24_s;
    logic [22:0]        frac_s;
    logic signed [9:0]  e2_s;
    logic [31:0]        res_s;
    logic               ovf_s;
    logic               unf_s;
    logic               inx_s;

    // Packs sign, biased exponent and fraction into a binary32 word.
    function automatic logic [31:0] pack(input logic s, input logic [7:0] e, input logic [22:0] f);
        return {s, e, f};
    endfunction

    assign s2_en_s  = !out_valid | out_ready;
    assign s1_en_s  = !s1_valid_r | s2_en_s;
    assign in_ready = s1_en_s;

    // Normalize: select the mantissa window from the product's leading bit.
    always_comb begin
        n1_exp_s = {2'b00, exp_a} + {2'b00, exp_b} - 10'sd127;
        if (prod[47]) begin
            n1_mant_s   = prod[46:24];
            n1_guard_s  = prod[23];
            n1_sticky_s = |prod[22:0];
            n1_exp_s    = n1_exp_s + 10'sd1;
        end else begin
            n1_mant_s   = prod[45:23];
            n1_guard_s  = prod[22];
            n1_sticky_s = |prod[21:0];
        end
    end

    // Stage 1 register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_r  <= 1'b0;
            s1_mant_r   <= 23'd0;
            s1_guard_r  <= 1'b0;
            s1_sticky_r <= 1'b0;
            s1_exp_r    <= 10'sd0;
            s1_sign_r   <= 1'b0;
            s1_cls_r    <= 2'b00;
        end else if (s1_en_s) begin
            s1_valid_r <= in_valid;
            if (in_valid) begin
                s1_mant_r   <= n1_mant_s;
                s1_guard_r  <= n1_guard_s;
                s1_sticky_r <= n1_sticky_s;
                s1_exp_r    <= n1_exp_s;
                s1_sign_r   <= sign;
                s1_cls_r    <= cls;
            end
        end
    end

    // Round to nearest even, then range-check the exponent and apply the class.
    always_comb begin
        round_up_s = s1_guard_r & (s1_sticky_r | s1_mant_r[0]);
        m24_s      = {1'b0, s1_mant_r} + {23'd0, round_up_s};
        if (m24_s[23]) begin
            frac_s = 23'd0;
            e2_s   = s1_exp_r + 10'sd1;
        end else begin
            frac_s = m24_s[22:0];
            e2_s   = s1_exp_r;
        end
        res_s = 32'd0;
        ovf_s = 1'b0;
        unf_s = 1'b0;
        inx_s = 1'b0;
        case (s1_cls_r)
            2'b00: begin
                if (e2_s >= 10'sd255) begin
                    res_s = pack(s1_sign_r, 8'hFF, 23'd0);
                    ovf_s = 1'b1;
                    inx_s = 1'b1;
                end else if (e2_s <= 10'sd0) begin
                    res_s = pack(s1_sign_r, 8'h00, 23'd0);
                    unf_s = 1'b1;
                    inx_s = 1'b1;
                end else begin
                    res_s = pack(s1_sign_r, e2_s[7:0], frac_s);
                    inx_s = s1_guard_r | s1_sticky_r;
                end
            end
            2'b01:   res_s = pack(s1_sign_r, 8'h00, 23'd0);
            2'b10:   res_s = pack(s1_sign_r, 8'hFF, 23'd0);
            2'b11:   res_s = 32'h7FC00000;
            default: res_s = 32'd0;
        endcase
    end

    // Stage 2 register; holds the beat while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid <= 1'b0;
            result    <= 32'd0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            inexact   <= 1'b0;
        end else if (s2_en_s) begin
            out_valid <= s1_valid_r;
            if (s1_valid_r) begin
                result    <= res_s;
                overflow  <= ovf_s;
                underflow <= unf_s;
                inexact   <= inx_s;
            end
        end
    end

endmodule
